// File: rtl/gray_ctrl_pkg.sv
// Shared definitions for the Gray-counter run/pause/step/clear controller.
package gray_ctrl_pkg;

    // Default flop stages per button synchroniser and speed-select width.
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DIV_W_DEFAULT       = 4;

    // Controller mode; the encoding is visible on the debug state port.
    typedef enum logic [1:0] {
        PAUSE = 2'b00,
        RUN   = 2'b01,
        STEP  = 2'b10,
        CLEAR = 2'b11
    } state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// Button synchroniser followed by a registered rising-edge detector.
// A level sampled high at edge k appears as a one-cycle pulse at edge
// k+SYNC_STAGES; holding the button yields a single pulse.
module btn_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic edge_out
);

    logic sync_reg [SYNC_STAGES];
    logic prev_reg;
    logic edge_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // First stage captures the asynchronous button level.
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= btn_in;
                end
            end else begin : g_next
                // Later stages settle any metastability from the first.
                always_ff @(posedge clk) begin
                    if (rst) sync_reg[gi] <= 1'b0;
                    else     sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    // Registered rising-edge detect on the synchronised level.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_reg <= 1'b0;
            edge_reg <= 1'b0;
        end else begin
            prev_reg <= sync_reg[SYNC_STAGES-1];
            edge_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign edge_out = edge_reg;

endmodule

// File: rtl/gray_counter_ctrl.sv
// Run/pause/step/clear controller for the Gray counter: synchronises the
// buttons, runs the mode FSM and a tick prescaler, and issues registered
// single-cycle enable and clear strobes to the counter.
module gray_counter_ctrl
    import gray_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DIV_W       = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_run,
    input  logic             btn_step,
    input  logic             btn_clr,
    input  logic [DIV_W-1:0] div_sel,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             running,
    output logic [1:0]       state
);

    localparam int NBTN = 3;

    logic [NBTN-1:0]  btn_vec;
    logic [NBTN-1:0]  edge_vec;
    logic             run_e;
    logic             step_e;
    logic             clr_e;

    state_t           state_reg;
    state_t           state_next;
    logic [DIV_W-1:0] pre_reg;
    logic [DIV_W-1:0] pre_next;
    logic             fire_reg;
    logic             fire_next;
    logic             cnt_en_reg;
    logic             cnt_clr_reg;
    logic             running_reg;

    assign btn_vec = {btn_clr, btn_step, btn_run};

    genvar gi;
    generate
        for (gi = 0; gi < NBTN; gi++) begin : g_btn
            btn_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .clk      (clk),
                .rst      (rst),
                .btn_in   (btn_vec[gi]),
                .edge_out (edge_vec[gi])
            );
        end
    endgenerate

    assign run_e  = edge_vec[0];
    assign step_e = edge_vec[1];
    assign clr_e  = edge_vec[2];

    // Next-state and prescaler logic; priority is clear > step > run > tick.
    // The prescaler only holds a value while staying in RUN, so it is zero
    // on entry to and on every exit from RUN.
    always_comb begin
        state_next = state_reg;
        pre_next   = '0;
        fire_next  = 1'b0;
        case (state_reg)
            PAUSE: begin
                if (clr_e)       state_next = CLEAR;
                else if (step_e) state_next = STEP;
                else if (run_e)  state_next = RUN;
            end
            RUN: begin
                if (clr_e) begin
                    state_next = CLEAR;
                end else if (run_e) begin
                    state_next = PAUSE;
                end else if (tick) begin
                    // >= lets a mid-run decrease of div_sel fire at the next tick.
                    if (pre_reg >= div_sel) fire_next = 1'b1;
                    else                    pre_next  = pre_reg + 1'b1;
                end else begin
                    pre_next = pre_reg;
                end
            end
            STEP:    state_next = PAUSE;
            CLEAR:   state_next = PAUSE;
            default: state_next = PAUSE;
        endcase
    end

    // State, prescaler and output registers; strobes follow one cycle
    // after the decision that causes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= PAUSE;
            pre_reg     <= '0;
            fire_reg    <= 1'b0;
            cnt_en_reg  <= 1'b0;
            cnt_clr_reg <= 1'b0;
            running_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pre_reg     <= pre_next;
            fire_reg    <= fire_next;
            cnt_en_reg  <= fire_reg | (state_reg == STEP);
            cnt_clr_reg <= (state_reg == CLEAR);
            running_reg <= (state_next == RUN);
        end
    end

    assign cnt_en  = cnt_en_reg;
    assign cnt_clr = cnt_clr_reg;
    assign running = running_reg;
    assign state   = state_reg;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// Self-checking bench for gray_counter_ctrl: scenario tasks plus a random
// phase, all compared each cycle against a timeline reference model.
module tb_gray_counter_ctrl;

    localparam int S    = 2;
    localparam int DW   = 4;
    localparam int MAXE = 8192;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          tick     = 1'b0;
    logic          btn_run  = 1'b0;
    logic          btn_step = 1'b0;
    logic          btn_clr  = 1'b0;
    logic [DW-1:0] div_sel  = '0;
    logic          cnt_en;
    logic          cnt_clr;
    logic          running;
    logic [1:0]    state;

    int errors = 0;
    int checks = 0;

    gray_counter_ctrl #(
        .SYNC_STAGES (S),
        .DIV_W       (DW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .btn_run  (btn_run),
        .btn_step (btn_step),
        .btn_clr  (btn_clr),
        .div_sel  (div_sel),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .running  (running),
        .state    (state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Button pulses come from the sampled-level history: a level high at
    // edge k and low at k-1 is a pulse at edge k+S, lost if reset hits the
    // path meanwhile. The mode follows the rule table; strobes are kept as
    // lists of edges at which they are due.
    typedef enum {M_PAUSE, M_RUN, M_STEP, M_CLEAR} mode_t;

    mode_t mode = M_PAUSE;
    int    e = 0;
    bit    lvl [3][MAXE];
    bit    rst_h [MAXE];
    bit    pulse_prev [3];
    int    ticks_since = 0;
    int    en_due[$];
    int    clr_due[$];
    bit    exp_en = 0;
    bit    exp_clr = 0;

    task automatic model_edge();
        bit pg [3];
        bit run_p, step_p, clr_p;
        if (e >= MAXE) begin
            $display("FAIL model_capacity e=%0d limit=%0d", e, MAXE);
            $fatal(1, "edge history exhausted");
        end
        rst_h[e]  = rst;
        lvl[0][e] = rst ? 1'b0 : btn_run;
        lvl[1][e] = rst ? 1'b0 : btn_step;
        lvl[2][e] = rst ? 1'b0 : btn_clr;
        for (int b = 0; b < 3; b++) begin
            pg[b] = 1'b0;
            if (e >= S + 1) begin
                pg[b] = lvl[b][e-S] && !lvl[b][e-S-1];
                for (int j = e - S + 1; j <= e; j++)
                    if (rst_h[j]) pg[b] = 1'b0;
            end
        end
        run_p  = pulse_prev[0];
        step_p = pulse_prev[1];
        clr_p  = pulse_prev[2];
        exp_en  = 1'b0;
        exp_clr = 1'b0;
        if (rst) begin
            mode = M_PAUSE;
            ticks_since = 0;
            en_due.delete();
            clr_due.delete();
        end else begin
            if (en_due.size() > 0 && en_due[0] == e) begin
                exp_en = 1'b1;
                void'(en_due.pop_front());
            end
            if (clr_due.size() > 0 && clr_due[0] == e) begin
                exp_clr = 1'b1;
                void'(clr_due.pop_front());
            end
            case (mode)
                M_PAUSE: begin
                    if (clr_p) begin
                        mode = M_CLEAR; clr_due.push_back(e + 1);
                    end else if (step_p) begin
                        mode = M_STEP; en_due.push_back(e + 1);
                    end else if (run_p) begin
                        mode = M_RUN; ticks_since = 0;
                    end
                end
                M_RUN: begin
                    if (clr_p) begin
                        mode = M_CLEAR; clr_due.push_back(e + 1);
                    end else if (run_p) begin
                        mode = M_PAUSE;
                    end else if (tick) begin
                        ticks_since++;
                        if (ticks_since > int'(div_sel)) begin
                            en_due.push_back(e + 1);
                            ticks_since = 0;
                        end
                    end
                end
                default: mode = M_PAUSE;
            endcase
        end
        pulse_prev = pg;
        e++;
    endtask

    function automatic logic [4:0] expected();
        logic [1:0] code;
        case (mode)
            M_PAUSE: code = 2'b00;
            M_RUN:   code = 2'b01;
            M_STEP:  code = 2'b10;
            default: code = 2'b11;
        endcase
        return {exp_en, exp_clr, (mode == M_RUN), code};
    endfunction

    // One clock: model follows the edge, outputs are read 1 ns later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [4:0] got;
        rst = 1'b1; btn_run = 1'b1; btn_step = 1'b1; btn_clr = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            got = {cnt_en, cnt_clr, running, state};
            if (got !== 5'b0) begin
                errors++;
                $display("FAIL reset_values e=%0d got=%b want=00000", e, got);
            end
            checks++;
        end
        rst = 1'b0; btn_step = 1'b0; btn_clr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            btn_run = (c < 8) || (c >= 10 && c < 12);
            step();
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL reset_release e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
            if (c == S + 1 && running !== 1'b1) begin
                errors++;
                $display("FAIL reset_run_latency e=%0d running=%b want=1", e, running);
            end
            if (c == S + 1) checks++;
        end
        if (state !== 2'b00) begin
            errors++;
            $display("FAIL reset_back_to_pause state=%b want=00", state);
        end
        checks++;
        btn_run = 1'b0;
    endtask

    task automatic test_stepping();
        logic [4:0] got;
        int ens = 0;
        int bad_lat = 0;
        for (int c = 0; c < 36; c++) begin
            btn_step = (c % 12) < 2;
            tick = (c % 4 == 1);
            step();
            tick = 1'b0;
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL stepping e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
            if (cnt_en === 1'b1) begin
                ens++;
                if ((c % 12) != S + 2) bad_lat++;
            end
        end
        btn_step = 1'b0;
        if (ens != 3 || bad_lat != 0) begin
            errors++;
            $display("FAIL step_pulses count=%0d late=%0d want count=3 late=0", ens, bad_lat);
        end
        checks++;
    endtask

    task automatic test_prescaler();
        logic [4:0] got;
        int fired[$];
        int stray = 0;
        div_sel = 4'd2;
        for (int c = 0; c < 6; c++) begin
            btn_run = (c < 2);
            step();
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL prescaler_enter e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
        end
        for (int t = 1; t <= 11; t++) begin
            if (t == 11) div_sel = 4'd0;
            for (int c = 0; c < 5; c++) begin
                tick = (c == 0);
                step();
                tick = 1'b0;
                got = {cnt_en, cnt_clr, running, state};
                if (got !== expected()) begin
                    errors++;
                    $display("FAIL prescaler_cycle e=%0d got=%b want=%b", e, got, expected());
                end
                checks++;
                if (cnt_en === 1'b1) begin
                    if (c == 1) fired.push_back(t);
                    else stray++;
                end
            end
        end
        if (fired.size() != 4 || stray != 0 ||
            fired[0] != 3 || fired[1] != 6 || fired[2] != 9 || fired[3] != 11) begin
            errors++;
            $display("FAIL prescaler_pattern fired=%p stray=%0d want fired='{3,6,9,11} stray=0", fired, stray);
        end
        checks++;
    endtask

    task automatic test_clear_vs_tick();
        logic [4:0] got;
        int clr_n = 0;
        int en_n = 0;
        int fired[$];
        div_sel = 4'd1;
        // one tick so the prescaler holds a non-zero count
        for (int c = 0; c < 4; c++) begin
            tick = (c == 0);
            step();
            tick = 1'b0;
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL clear_prep e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
        end
        for (int c = 0; c < 10; c++) begin
            btn_clr = (c < 2);
            tick = (c == S + 1);
            step();
            tick = 1'b0;
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL clear_vs_tick e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
            if (cnt_clr === 1'b1) clr_n++;
            if (cnt_en === 1'b1) en_n++;
        end
        btn_clr = 1'b0;
        if (clr_n != 1 || en_n != 0 || state !== 2'b00) begin
            errors++;
            $display("FAIL clear_wins clr=%0d en=%0d state=%b want clr=1 en=0 state=00", clr_n, en_n, state);
        end
        checks++;
        // back to RUN: a cleared prescaler needs two ticks at div_sel=1
        for (int c = 0; c < 6; c++) begin
            btn_run = (c < 2);
            step();
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL clear_rerun e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
        end
        btn_run = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            for (int c = 0; c < 4; c++) begin
                tick = (c == 0);
                step();
                tick = 1'b0;
                got = {cnt_en, cnt_clr, running, state};
                if (got !== expected()) begin
                    errors++;
                    $display("FAIL clear_pre_zero e=%0d got=%b want=%b", e, got, expected());
                end
                checks++;
                if (cnt_en === 1'b1) fired.push_back(t);
            end
        end
        if (fired.size() != 1 || fired[0] != 2) begin
            errors++;
            $display("FAIL clear_pre_reset fired=%p want '{2}", fired);
        end
        checks++;
    endtask

    task automatic test_step_ignored_long_press();
        logic [4:0] got;
        int falls = 0;
        int rises = 0;
        logic prev_run;
        div_sel = DW'($urandom_range(0, 2));
        prev_run = running;
        for (int c = 0; c < 80; c++) begin
            btn_step = (c >= 2 && c < 4);
            btn_run = (c >= 20 && c < 70);
            tick = (c % 3 == 0);
            step();
            tick = 1'b0;
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL step_in_run e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
            if (prev_run === 1'b1 && running === 1'b0) falls++;
            if (prev_run === 1'b0 && running === 1'b1) rises++;
            prev_run = running;
        end
        btn_step = 1'b0; btn_run = 1'b0;
        if (falls != 1 || rises != 0 || state !== 2'b00) begin
            errors++;
            $display("FAIL long_press falls=%0d rises=%0d state=%b want 1 0 00", falls, rises, state);
        end
        checks++;
    endtask

    task automatic test_reset_mid_run();
        logic [4:0] got;
        div_sel = 4'd0;
        for (int c = 0; c < 6; c++) begin
            btn_run = (c < 2);
            step();
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL midrun_enter e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
        end
        btn_run = 1'b0;
        tick = 1'b1;
        step();
        tick = 1'b0;
        rst = 1'b1;
        step();
        if (cnt_en !== 1'b0 || state !== 2'b00 || running !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run en=%b state=%b running=%b want 0 00 0", cnt_en, state, running);
        end
        checks++;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL midrun_after e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
        end
    endtask

    task automatic test_random();
        logic [4:0] got;
        int hold [3];
        int rate [3];
        bit last_tick = 1'b0;
        rate[0] = 15; rate[1] = 25; rate[2] = 45;
        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 500; c++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] > 0) hold[b]--;
                else if ($urandom_range(0, rate[b]) == 0) hold[b] = $urandom_range(1, 6);
            end
            btn_run  = hold[0] > 0;
            btn_step = hold[1] > 0;
            btn_clr  = hold[2] > 0;
            tick = !last_tick && ($urandom_range(0, 2) == 0);
            last_tick = tick;
            if ($urandom_range(0, 49) == 0) div_sel = DW'($urandom_range(0, 4));
            rst = ($urandom_range(0, 249) == 0);
            step();
            got = {cnt_en, cnt_clr, running, state};
            if (got !== expected()) begin
                errors++;
                $display("FAIL random e=%0d got=%b want=%b", e, got, expected());
            end
            checks++;
        end
        rst = 1'b0; tick = 1'b0;
        btn_run = 1'b0; btn_step = 1'b0; btn_clr = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_stepping();
        test_prescaler();
        test_clear_vs_tick();
        test_step_ignored_long_press();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_counter_ctrl.md
# gray_counter_ctrl

Run/pause/step/clear controller for the Gray-counter LED system. Sits between the board push-buttons, the 1 Hz pulse generator and the N-bit Gray counter. Synchronises and edge-detects three buttons, runs a small mode FSM, and issues single-cycle enable and clear strobes to the counter's `clk_en` and clear inputs. A programmable tick prescaler sets the counting speed.

## Interface
- `SYNC_STAGES`, 2 – flip-flop stages in each button synchroniser (≥2).
- `DIV_W`, 4 – width of the speed-select input.
- `clk` in 1 – system clock (100 MHz board clock).
- `rst` in 1 – reset, synchronous, active-high.
- `tick` in 1 – one-cycle pulse from the pulse generator (1 Hz).
- `btn_run` in 1 – asynchronous button; a rising edge toggles RUN/PAUSE.
- `btn_step` in 1 – asynchronous button; a rising edge advances the counter once while paused.
- `btn_clr` in 1 – asynchronous button; a rising edge clears the counter.
- `div_sel` in DIV_W – advance once every `div_sel+1` ticks; quasi-static.
- `cnt_en` out 1 – registered one-cycle enable to the counter's `clk_en`.
- `cnt_clr` out 1 – registered one-cycle synchronous clear to the counter.
- `running` out 1 – high while the state is RUN (drives a status LED).
- `state` out 2 – current FSM state, for debug.

## Operation
- **Button path**
  - Each button passes through a `SYNC_STAGES` flop chain, then a registered rising-edge detector.
  - This yields the internal pulses `run_e`, `step_e` and `clr_e`, each one cycle wide per press.
  - Holding a button produces exactly one pulse. No debounce is done here; inputs are already debounced.
- **FSM states** (encoding): PAUSE=2'b00, RUN=2'b01, STEP=2'b10, CLEAR=2'b11.
- **Transition priority** within a cycle: `clr_e` > `step_e` > `run_e` > `tick`.
- **PAUSE**
  - `clr_e` → CLEAR.
  - `step_e` → STEP.
  - `run_e` → RUN.
  - `tick` is ignored.
- **RUN**
  - `clr_e` → CLEAR.
  - `run_e` → PAUSE.
  - `step_e` is ignored.
  - On `tick`: if `pre >= div_sel`, then `pre` ← 0 and `cnt_en` is set for one cycle; otherwise `pre` ← `pre+1`.
- **STEP**
  - Lasts one cycle with `cnt_en`=1, then → PAUSE.
  - Any button pulse arriving during STEP is dropped.
- **CLEAR**
  - Lasts one cycle with `cnt_clr`=1, then → PAUSE.
  - The prescaler `pre` ← 0.
  - Pulses arriving during CLEAR are dropped.
- **Prescaler `pre`** (DIV_W bits)
  - Resets to 0 on every exit from RUN and on entry to RUN.
  - Comparing with `>=` makes a mid-run decrease of `div_sel` take effect at the next tick without overrun.
- **Output rules**
  - `cnt_en` and `cnt_clr` are mutually exclusive.
  - Each is never high for two consecutive cycles.
  - A `tick` coinciding with `clr_e` in RUN is discarded; the clear wins.
- **Reset**
  - Effective at the clock edge where `rst`=1.
  - State → PAUSE; `pre`, `cnt_en`, `cnt_clr` and `running` → 0; the synchroniser and edge registers → 0.
  - A button held high through reset release therefore produces one edge pulse after release.
  - Reset mid-RUN drops any pending enable.

## Timing
- **Button to state:** a button sampled high at edge k produces its edge pulse at edge k+SYNC_STAGES. The state update occurs at edge k+SYNC_STAGES+1.
- **STEP and CLEAR strobes:** `cnt_en` for STEP, and `cnt_clr` for CLEAR, are high in the cycle after the state update. Button-to-strobe latency is SYNC_STAGES+2 cycles.
- **Tick to enable:** a `tick` sampled at edge t in RUN produces `cnt_en` high from edge t+1 to edge t+2. The counter advances at edge t+2.
- **Status outputs:** `running` and `state` are registered and change together with the state.
- **Counting rate:** in RUN with a 1 Hz `tick`, the counter advances at 1/(`div_sel`+1) Hz.

## Structure
- **Package `gray_ctrl_pkg`:** contains
  - the state encoding constants (PAUSE, RUN, STEP, CLEAR) and the 2-bit state type;
  - the default values for `SYNC_STAGES` and `DIV_W`.
- **Sub-module `btn_sync_edge`:** parameterised by `SYNC_STAGES`, with ports `clk`, `rst`, `btn_in`, `edge_out`. It is instantiated three times.
- **Top module:** holds the FSM, the prescaler and the output registers.
- **Integration:** the system top instantiates `gray_counter_ctrl` between the pulse generator and the Gray counter. `cnt_en` drives the counter's `clk_en` and `cnt_clr` drives its clear.

## Test plan
- **Reset values:** `rst`=1 for 3 cycles with all buttons high → after release, `state`=00 and all outputs 0. A single `run_e` follows and `running`=1 by cycle SYNC_STAGES+1.
- **Stepping:** from PAUSE, press `btn_step` 3 times with 10-cycle gaps → exactly 3 one-cycle `cnt_en` pulses, each SYNC_STAGES+2 cycles after its press. `running` stays 0 and `tick` is ignored.
- **Prescaler:** set `div_sel`=2, enter RUN, apply 9 ticks spaced 5 cycles apart → `cnt_en` fires after ticks 3, 6 and 9 only, each one cycle after its tick. Change `div_sel` to 0 mid-run → the next tick fires.
- **Clear vs. tick:** in RUN, assert `clr_e` in the same cycle as `tick` → `cnt_clr` pulses once, `cnt_en` stays 0, and the state ends in PAUSE with `pre`=0.
- **Ignored step and long press:** in RUN, press `btn_step` → no `cnt_en` beyond normal tick enables. Then hold `btn_run` for 50 cycles → exactly one RUN→PAUSE transition.
- **Reset mid-run:** assert `rst` one cycle after a qualifying `tick` in RUN → `cnt_en` is 0 on the following cycle and the state is PAUSE.
